// File: rtl/msk_gfmul_hpc1_pipe.sv
// Masked HPC1 GF(2^N) multiplier, d shares: SNI refresh of b, then DOM share-wise product.
// Three register levels (b'/a, cross terms, out); out_valid tracks items through vld_pipe.
module msk_gfmul_hpc1_gf #(
  parameter int          N   = 2,
  parameter logic [N-1:0] RED = '1
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] p
);
  logic [N-1:0] t;

  // Shift-and-add with reduction folded into every doubling of x
  always_comb begin
    p = '0;
    t = x;
    for (int k = 0; k < N; k++) begin
      if (y[k]) p = p ^ t;
      t = {t[N-2:0], 1'b0} ^ (t[N-1] ? RED : '0);
    end
  end
endmodule

module msk_gfmul_hpc1_pipe #(
  parameter int         d       = 2,
  parameter int         N       = 2,
  parameter logic [N:0] POLY    = 3'b111,
  parameter int         A_DELAY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [N*d-1:0]           ina,
  input  logic [N*d-1:0]           inb,
  input  logic [N*(d-1)-1:0]       rnd_ref,
  input  logic [N*d*(d-1)/2-1:0]   rnd_mul,
  output logic [N*d-1:0]           out,
  output logic                     out_valid
);
  localparam int STAGES = 2;

  if (!(d == 2 || d == 3)) begin : g_bad_d
    $error("msk_gfmul_hpc1_pipe: d must be 2 or 3");
  end
  if (N < 2 || N > 8) begin : g_bad_n
    $error("msk_gfmul_hpc1_pipe: N must be in 2..8");
  end
  if (POLY[N] != 1'b1) begin : g_bad_poly
    $error("msk_gfmul_hpc1_pipe: POLY must have bit N set");
  end
  if (!(A_DELAY == 0 || A_DELAY == 1)) begin : g_bad_adly
    $error("msk_gfmul_hpc1_pipe: A_DELAY must be 0 or 1");
  end

  // Position of pair (i,j), i<j, in lexicographic order of all such pairs
  function automatic int pair_idx(input int i, input int j);
    int n;
    n = 0;
    for (int q = 0; q < i; q++) n += d - 1 - q;
    return n + j - i - 1;
  endfunction

  logic [d-1:0][N-1:0]         a_in, b_in, b_ref, b_q, a_s1, o_sh, o_q;
  logic [d-2:0][N-1:0]         r_ref;
  logic [d-1:0][d-1:0][N-1:0]  prod, term_d, term_q;
  logic [STAGES:0]             vld_pipe;

  for (genvar s = 0; s < d; s++) begin : g_share
    for (genvar k = 0; k < N; k++) begin : g_bit
      assign a_in[s][k]   = ina[k*d+s];
      assign b_in[s][k]   = inb[k*d+s];
      assign out[k*d+s]   = o_q[s][k];
    end
    if (s == 0) begin : g_first
      assign b_ref[s] = b_in[s] ^ r_ref[0];
    end else if (s == d-1) begin : g_last
      assign b_ref[s] = b_in[s] ^ r_ref[s-1];
    end else begin : g_mid
      assign b_ref[s] = b_in[s] ^ r_ref[s-1] ^ r_ref[s];
    end
  end

  for (genvar s = 0; s < d-1; s++) begin : g_rref
    assign r_ref[s] = rnd_ref[s*N +: N];
  end

  if (A_DELAY == 1) begin : g_areg
    logic [d-1:0][N-1:0] a_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        a_q <= '0;
      else if (in_valid) a_q <= a_in;
    end
    assign a_s1 = a_q;
  end else begin : g_adir
    // Caller already skews ina by one cycle, so it lines up with b_q here
    assign a_s1 = a_in;
  end

  for (genvar i = 0; i < d; i++) begin : g_row
    for (genvar j = 0; j < d; j++) begin : g_col
      msk_gfmul_hpc1_gf #(.N(N), .RED(POLY[N-1:0])) u_gf (
        .x (a_s1[i]),
        .y (b_q[j]),
        .p (prod[i][j])
      );
      if (i == j) begin : g_diag
        assign term_d[i][j] = prod[i][j];
      end else if (i < j) begin : g_up
        assign term_d[i][j] = prod[i][j] ^ rnd_mul[pair_idx(i, j)*N +: N];
      end else begin : g_lo
        assign term_d[i][j] = prod[i][j] ^ rnd_mul[pair_idx(j, i)*N +: N];
      end
    end
  end

  always_comb begin
    o_sh = '0;
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++)
        o_sh[i] = o_sh[i] ^ term_q[i][j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      b_q      <= '0;
      term_q   <= '0;
      o_q      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      if (in_valid)    b_q    <= b_ref;
      if (vld_pipe[0]) term_q <= term_d;
      if (vld_pipe[1]) o_q    <= o_sh;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule
